spike_net_interface: RTL

- Network interface between one mesh node's CPU data-memory port and its local router port.
- TX path: the CPU posts spike events, and the block packs them into 32-bit flits, queues them and injects them into the router under valid/ready.
- RX path: flits ejected by the router are queued for the CPU to read.
- Self-addressed spikes loop back locally and never enter the router.

---
 rtl/spike_noc_pkg.sv | 31 +++
 rtl/spike_net_interface_sync_fifo.sv | 58 +++++
 rtl/spike_net_interface.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/spike_noc_pkg.sv
// Shared flit layout for the spike mesh: field positions, field widths and
// the pack helper used by the network interface.
package spike_noc_pkg;

  localparam int FLIT_W   = 32;
  localparam int COORD_W  = 4;
  localparam int NEURON_W = 16;
  // RX entries keep only what the CPU reads back: {src_x, src_y, neuron}.
  localparam int RX_W     = 2 * COORD_W + NEURON_W;

  localparam int DEST_X_LSB = 28;
  localparam int DEST_Y_LSB = 24;
  localparam int SRC_X_LSB  = 20;
  localparam int SRC_Y_LSB  = 16;
  localparam int NEURON_LSB = 0;

  function automatic logic [FLIT_W-1:0] pack_flit(
    input logic [COORD_W-1:0]  dest_x,
    input logic [COORD_W-1:0]  dest_y,
    input logic [COORD_W-1:0]  src_x,
    input logic [COORD_W-1:0]  src_y,
    input logic [NEURON_W-1:0] neuron
  );
    return {dest_x, dest_y, src_x, src_y, neuron};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/spike_net_interface_sync_fifo.sv
// Synchronous FIFO with a separate occupancy count; a pop makes room for a
// push on the same edge. peek_next selects the entry behind the head.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       peek_next,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_idx  = rd_ptr + AW'(peek_next);
  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spike_net_interface.sv
// Mesh node network interface: CPU spike posts go to the router (TX FIFO) or
// loop back locally (RX FIFO). Optional counters under SPIKE_NI_STATS_EN.
module spike_net_interface
  import spike_noc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spk_wr,
  input  logic [3:0]            spk_dest_x,
  input  logic [3:0]            spk_dest_y,
  input  logic [15:0]           spk_neuron,
  output logic                  spk_busywait,
  output logic                  rtr_out_valid,
  output logic [DATA_WIDTH-1:0] rtr_out_flit,
  input  logic                  rtr_out_ready,
  input  logic                  rtr_in_valid,
  input  logic [DATA_WIDTH-1:0] rtr_in_flit,
  output logic                  rtr_in_ready,
  input  logic                  rx_rd,
  output logic                  rx_empty,
  output logic [15:0]           rx_neuron,
  output logic [3:0]            rx_src_x,
  output logic [3:0]            rx_src_y
`ifdef SPIKE_NI_STATS_EN
  ,
  output logic [15:0]           stat_tx_cnt,
  output logic [15:0]           stat_rx_cnt,
  output logic [15:0]           stat_loop_cnt,
  output logic [15:0]           stat_misroute_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]         CNT_ONE = (AW + 1)'(1);
  localparam logic [COORD_W-1:0]  MY_X    = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0]  MY_Y    = COORD_W'(Y_ID);

  logic                  is_local;
  logic                  tx_push, tx_pop, tx_full, tx_empty;
  logic [AW:0]           tx_count;
  logic [DATA_WIDTH-1:0] tx_wdata, tx_head;
  logic                  out_valid_d;
  logic                  rx_push, rx_pop, rx_can, rx_full, rx_fifo_empty;
  logic [AW:0]           rx_count;
  logic [RX_W-1:0]       rx_wdata, rx_head;
  logic                  rtr_take, loop_take;

  assign is_local = (spk_dest_x == MY_X) && (spk_dest_y == MY_Y);
  assign tx_wdata = pack_flit(spk_dest_x, spk_dest_y, MY_X, MY_Y, spk_neuron);

  // Valid/ready on both router ports: a flit moves on an edge where valid and
  // ready are both high; valid never drops and data never changes until then.
  assign tx_pop  = rtr_out_valid & rtr_out_ready;
  assign tx_push = spk_wr & ~is_local & (~tx_full | tx_pop);

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (tx_wdata),
    .pop       (tx_pop),
    .peek_next (tx_pop),
    .rd_data   (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // The output register mirrors the head the FIFO will hold after this edge's
  // pop, so a newly posted flit shows up one edge after it is written.
  assign out_valid_d = tx_pop ? (tx_count > CNT_ONE) : ~tx_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rtr_out_valid <= 1'b0;
      rtr_out_flit  <= '0;
    end else begin
      rtr_out_valid <= out_valid_d;
      rtr_out_flit  <= out_valid_d ? tx_head : '0;
    end
  end

  // Router flits win the RX write port; a local post waits behind them.
  assign rx_pop       = rx_rd & (rx_count != '0);
  assign rx_can       = ~rx_full | rx_pop;
  assign rtr_in_ready = rx_can;
  assign rtr_take     = rtr_in_valid & rx_can;
  assign loop_take    = spk_wr & is_local & rx_can & ~rtr_in_valid;
  assign rx_push      = rtr_take | loop_take;
  assign rx_wdata     = rtr_take ? {rtr_in_flit[SRC_X_LSB +: COORD_W],
                                    rtr_in_flit[SRC_Y_LSB +: COORD_W],
                                    rtr_in_flit[NEURON_LSB +: NEURON_W]}
                                 : {MY_X, MY_Y, spk_neuron};

  assign spk_busywait = spk_wr & ~(tx_push | loop_take);

  sync_fifo #(.WIDTH(RX_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_wdata),
    .pop       (rx_pop),
    .peek_next (1'b0),
    .rd_data   (rx_head),
    .full      (rx_full),
    .empty     (rx_fifo_empty),
    .count     (rx_count)
  );

  assign rx_empty  = rx_fifo_empty;
  assign rx_src_x  = rx_fifo_empty ? '0 : rx_head[RX_W-1 -: COORD_W];
  assign rx_src_y  = rx_fifo_empty ? '0 : rx_head[NEURON_W +: COORD_W];
  assign rx_neuron = rx_fifo_empty ? '0 : rx_head[NEURON_W-1:0];

`ifdef SPIKE_NI_STATS_EN
  logic misroute;
  assign misroute = rtr_take & ((rtr_in_flit[DEST_X_LSB +: COORD_W] != MY_X) |
                                (rtr_in_flit[DEST_Y_LSB +: COORD_W] != MY_Y));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_tx_cnt       <= '0;
      stat_rx_cnt       <= '0;
      stat_loop_cnt     <= '0;
      stat_misroute_cnt <= '0;
    end else begin
      if (tx_pop)    stat_tx_cnt       <= sat_inc(stat_tx_cnt);
      if (rtr_take)  stat_rx_cnt       <= sat_inc(stat_rx_cnt);
      if (loop_take) stat_loop_cnt     <= sat_inc(stat_loop_cnt);
      if (misroute)  stat_misroute_cnt <= sat_inc(stat_misroute_cnt);
    end
  end
`else
  // Destination bits of received flits only matter to the misroute counter.
  logic unused_rx_dest;
  assign unused_rx_dest = ^{rtr_in_flit[DEST_X_LSB +: COORD_W],
                            rtr_in_flit[DEST_Y_LSB +: COORD_W]};
`endif

endmodule
